// File: rtl/prt_stream_if.sv
// Handshake/bus bundle for the packet reference table (prt_stream).
// The free_count signal exists only when PRT_FREE_COUNT_EN is defined.
interface prt_stream_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned NUM_SLOTS  = 16
);
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
`ifdef PRT_FREE_COUNT_EN
    localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
    logic [CNT_W-1:0]      free_count;
`endif

    logic                  wr_alloc_req;
    logic                  wr_alloc_ack;
    logic [SLOT_W-1:0]     wr_alloc_slot;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_done;
    logic [LEN_W-1:0]      wr_done_len;
    logic                  wr_overflow;
    logic                  rd_start_req;
    logic [SLOT_W-1:0]     rd_start_slot;
    logic                  rd_start_ack;
    logic                  rd_start_err;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  inv_req;
    logic [SLOT_W-1:0]     inv_slot;
    logic                  inv_ack;
    logic                  inv_err;
    logic                  free_any;

    modport master (
`ifdef PRT_FREE_COUNT_EN
        input  free_count,
`endif
        output wr_alloc_req, wr_valid, wr_data, wr_last,
        output rd_start_req, rd_start_slot, rd_ready,
        output inv_req, inv_slot,
        input  wr_alloc_ack, wr_alloc_slot, wr_ready, wr_done, wr_done_len, wr_overflow,
        input  rd_start_ack, rd_start_err, rd_valid, rd_data, rd_last,
        input  inv_ack, inv_err, free_any
    );

    modport slave (
`ifdef PRT_FREE_COUNT_EN
        output free_count,
`endif
        input  wr_alloc_req, wr_valid, wr_data, wr_last,
        input  rd_start_req, rd_start_slot, rd_ready,
        input  inv_req, inv_slot,
        output wr_alloc_ack, wr_alloc_slot, wr_ready, wr_done, wr_done_len, wr_overflow,
        output rd_start_ack, rd_start_err, rd_valid, rd_data, rd_last,
        output inv_ack, inv_err, free_any
    );
endinterface

// File: rtl/prt_stream.sv
// Packet reference table: NUM_SLOTS packet buffers with independent streaming write/read channels.
// Define PRT_FREE_COUNT_EN to add the registered free_count occupancy output.
module prt_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned NUM_SLOTS  = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    prt_stream_if.slave  bus
);
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ADDR_W = $clog2(NUM_SLOTS * DEPTH);
`ifdef PRT_FREE_COUNT_EN
    localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
`endif

    typedef enum logic [1:0] {S_FREE, S_WRITING, S_VALID, S_READING} slot_st_e;
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DRAIN} wr_st_e;
    typedef enum logic       {R_IDLE, R_ACTIVE} rd_st_e;

    slot_st_e              slot_q [NUM_SLOTS];
    slot_st_e              slot_d [NUM_SLOTS];
    logic [LEN_W-1:0]      len_q  [NUM_SLOTS];
    logic [LEN_W-1:0]      len_d  [NUM_SLOTS];

    wr_st_e                w_q, w_d;
    logic [SLOT_W-1:0]     wslot_q, wslot_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic                  alloc_ack_q, alloc_ack_d;
    logic [SLOT_W-1:0]     alloc_slot_q, alloc_slot_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  done_q, done_d;
    logic [LEN_W-1:0]      done_len_q, done_len_d;
    logic                  ovf_q, ovf_d;

    rd_st_e                r_q, r_d;
    logic [SLOT_W-1:0]     rslot_q, rslot_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [LEN_W-1:0]      rlen_q, rlen_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  st_ack_q, st_ack_d;
    logic                  st_err_q, st_err_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  inv_ack_q, inv_ack_d;
    logic                  inv_err_q, inv_err_d;

    logic                  free_found_c;
    logic [SLOT_W-1:0]     free_idx_c;
    logic                  wr_acc_c;
    logic                  mem_we_c;
    logic                  rd_load_c;
    logic                  rd_claim_c;
    logic                  last_fetch_c;
    logic [ADDR_W-1:0]     waddr_c;
    logic [ADDR_W-1:0]     raddr_c;

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS * DEPTH];

`ifdef PRT_FREE_COUNT_EN
    logic [CNT_W-1:0]      free_count_q, free_count_d;
`endif

    // Lowest-index FREE slot, from the pre-update slot states
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!free_found_c && slot_q[i] == S_FREE) begin
                free_found_c = 1'b1;
                free_idx_c   = SLOT_W'(i);
            end
        end
    end

    assign waddr_c      = ADDR_W'(wslot_q) * ADDR_W'(DEPTH) + ADDR_W'(wptr_q);
    assign raddr_c      = ADDR_W'(rslot_q) * ADDR_W'(DEPTH) + ADDR_W'(rptr_q);
    assign wr_acc_c     = bus.wr_valid && wr_ready_q;
    assign last_fetch_c = (LEN_W'(rptr_q) + LEN_W'(1)) == rlen_q;

    // Next-state logic for write FSM, read FSM, invalidate and slot metadata
    always_comb begin
        slot_d       = slot_q;
        len_d        = len_q;
        w_d          = w_q;
        wslot_d      = wslot_q;
        wptr_d       = wptr_q;
        alloc_ack_d  = 1'b0;
        alloc_slot_d = '0;
        done_d       = 1'b0;
        done_len_d   = '0;
        ovf_d        = 1'b0;
        mem_we_c     = 1'b0;
        r_d          = r_q;
        rslot_d      = rslot_q;
        rptr_d       = rptr_q;
        rlen_d       = rlen_q;
        fetch_done_d = fetch_done_q;
        st_ack_d     = 1'b0;
        st_err_d     = 1'b0;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_load_c    = 1'b0;
        rd_claim_c   = 1'b0;
        inv_ack_d    = 1'b0;
        inv_err_d    = 1'b0;

        case (w_q)
            W_IDLE: begin
                if (bus.wr_alloc_req && free_found_c) begin
                    slot_d[free_idx_c] = S_WRITING;
                    wslot_d            = free_idx_c;
                    wptr_d             = '0;
                    alloc_ack_d        = 1'b1;
                    alloc_slot_d       = free_idx_c;
                    w_d                = W_ACTIVE;
                end
            end
            W_ACTIVE: begin
                if (wr_acc_c) begin
                    mem_we_c = 1'b1;
                    if (bus.wr_last) begin
                        slot_d[wslot_q] = S_VALID;
                        len_d[wslot_q]  = LEN_W'(wptr_q) + LEN_W'(1);
                        done_d          = 1'b1;
                        done_len_d      = LEN_W'(wptr_q) + LEN_W'(1);
                        w_d             = W_IDLE;
                    end else if (wptr_q == PTR_W'(DEPTH - 1)) begin
                        w_d = W_DRAIN;
                    end else begin
                        wptr_d = wptr_q + PTR_W'(1);
                    end
                end
            end
            W_DRAIN: begin
                // Oversized packet: discard the tail and release the slot
                if (wr_acc_c && bus.wr_last) begin
                    slot_d[wslot_q] = S_FREE;
                    done_d          = 1'b1;
                    ovf_d           = 1'b1;
                    done_len_d      = LEN_W'(DEPTH);
                    w_d             = W_IDLE;
                end
            end
            default: w_d = W_IDLE;
        endcase
        wr_ready_d = (w_d == W_ACTIVE) || (w_d == W_DRAIN);

        case (r_q)
            R_IDLE: begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
                if (bus.rd_start_req) begin
                    if (slot_q[bus.rd_start_slot] == S_VALID) begin
                        rd_claim_c                   = 1'b1;
                        slot_d[bus.rd_start_slot]    = S_READING;
                        rslot_d                      = bus.rd_start_slot;
                        rptr_d                       = '0;
                        rlen_d                       = len_q[bus.rd_start_slot];
                        fetch_done_d                 = 1'b0;
                        st_ack_d                     = 1'b1;
                        r_d                          = R_ACTIVE;
                    end else begin
                        st_err_d = 1'b1;
                    end
                end
            end
            R_ACTIVE: begin
                st_err_d = bus.rd_start_req;
                if (rd_valid_q && bus.rd_ready && rd_last_q) begin
                    slot_d[rslot_q] = S_VALID;
                    r_d             = R_IDLE;
                    rd_valid_d      = 1'b0;
                    rd_last_d       = 1'b0;
                end else if (!rd_valid_q || bus.rd_ready) begin
                    // Output register is free next cycle: refill straight from memory
                    if (!fetch_done_q) begin
                        rd_load_c    = 1'b1;
                        rd_valid_d   = 1'b1;
                        rd_last_d    = last_fetch_c;
                        fetch_done_d = last_fetch_c;
                        rptr_d       = rptr_q + PTR_W'(1);
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end
            end
            default: r_d = R_IDLE;
        endcase

        // A read start on the same slot in the same cycle takes priority
        if (bus.inv_req) begin
            if (slot_q[bus.inv_slot] == S_VALID &&
                !(rd_claim_c && bus.rd_start_slot == bus.inv_slot)) begin
                slot_d[bus.inv_slot] = S_FREE;
                inv_ack_d            = 1'b1;
            end else begin
                inv_err_d = 1'b1;
            end
        end
    end

`ifdef PRT_FREE_COUNT_EN
    always_comb begin
        free_count_d = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_d[i] == S_FREE) free_count_d = free_count_d + CNT_W'(1);
        end
    end
`endif

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_q[i] <= S_FREE;
                len_q[i]  <= '0;
            end
            w_q          <= W_IDLE;
            wslot_q      <= '0;
            wptr_q       <= '0;
            alloc_ack_q  <= 1'b0;
            alloc_slot_q <= '0;
            wr_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            done_len_q   <= '0;
            ovf_q        <= 1'b0;
            r_q          <= R_IDLE;
            rslot_q      <= '0;
            rptr_q       <= '0;
            rlen_q       <= '0;
            fetch_done_q <= 1'b0;
            st_ack_q     <= 1'b0;
            st_err_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            inv_ack_q    <= 1'b0;
            inv_err_q    <= 1'b0;
`ifdef PRT_FREE_COUNT_EN
            free_count_q <= CNT_W'(NUM_SLOTS);
`endif
        end else begin
            slot_q       <= slot_d;
            len_q        <= len_d;
            w_q          <= w_d;
            wslot_q      <= wslot_d;
            wptr_q       <= wptr_d;
            alloc_ack_q  <= alloc_ack_d;
            alloc_slot_q <= alloc_slot_d;
            wr_ready_q   <= wr_ready_d;
            done_q       <= done_d;
            done_len_q   <= done_len_d;
            ovf_q        <= ovf_d;
            r_q          <= r_d;
            rslot_q      <= rslot_d;
            rptr_q       <= rptr_d;
            rlen_q       <= rlen_d;
            fetch_done_q <= fetch_done_d;
            st_ack_q     <= st_ack_d;
            st_err_q     <= st_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            inv_ack_q    <= inv_ack_d;
            inv_err_q    <= inv_err_d;
`ifdef PRT_FREE_COUNT_EN
            free_count_q <= free_count_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we_c) mem_q[waddr_c] <= bus.wr_data;
    end

    // Read-data output register doubles as the synchronous RAM read port
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)         rd_data_q <= '0;
        else if (rd_load_c) rd_data_q <= mem_q[raddr_c];
    end

    assign bus.wr_alloc_ack  = alloc_ack_q;
    assign bus.wr_alloc_slot = alloc_slot_q;
    assign bus.wr_ready      = wr_ready_q;
    assign bus.wr_done       = done_q;
    assign bus.wr_done_len   = done_len_q;
    assign bus.wr_overflow   = ovf_q;
    assign bus.rd_start_ack  = st_ack_q;
    assign bus.rd_start_err  = st_err_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_last       = rd_last_q;
    assign bus.inv_ack       = inv_ack_q;
    assign bus.inv_err       = inv_err_q;
    assign bus.free_any      = free_found_c;
`ifdef PRT_FREE_COUNT_EN
    assign bus.free_count    = free_count_q;
`endif
endmodule

// File: tb/tb_prt_stream.sv
// Directed self-checking bench for prt_stream (small geometry: 4 slots x 16 words).
module tb_prt_stream;
    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NS     = 4;
    localparam int unsigned SLOT_W = $clog2(NS);

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    prt_stream_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_SLOTS(NS)) bus ();

    prt_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_SLOTS(NS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_wr"}, 32'({bus.wr_alloc_ack, bus.wr_alloc_slot, bus.wr_ready,
                                    bus.wr_done, bus.wr_done_len, bus.wr_overflow}), 0);
        check_eq({tag, "_rd"}, 32'({bus.rd_start_ack, bus.rd_start_err, bus.rd_valid,
                                    bus.rd_data, bus.rd_last}), 0);
        check_eq({tag, "_inv"}, 32'({bus.inv_ack, bus.inv_err}), 0);
        check_eq({tag, "_free_any"}, 32'(bus.free_any), 1);
`ifdef PRT_FREE_COUNT_EN
        check_eq({tag, "_free_count"}, 32'(bus.free_count), NS);
`endif
    endtask

    task automatic do_alloc(input string tag, input int exp_slot);
        bit got = 1'b0;
        bus.wr_alloc_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (bus.wr_alloc_ack) begin
                got = 1'b1;
                check_eq({tag, "_slot"}, 32'(bus.wr_alloc_slot), 32'(exp_slot));
            end
        end
        bus.wr_alloc_req = 1'b0;
        check_eq({tag, "_ack"}, 32'(got), 1);
    endtask

    task automatic write_pkt(input string tag, input int n, input int base,
                             input int exp_len, input bit exp_ovf);
        bit rdy_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(base + i);
            bus.wr_last  = (i == n - 1);
            if (!bus.wr_ready) rdy_all = 1'b0;
            @(negedge CLK);
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        check_eq({tag, "_ready_held"}, 32'(rdy_all), 1);
        check_eq({tag, "_done"}, 32'(bus.wr_done), 1);
        check_eq({tag, "_len"}, 32'(bus.wr_done_len), 32'(exp_len));
        check_eq({tag, "_ovf"}, 32'(bus.wr_overflow), 32'(exp_ovf));
    endtask

    task automatic read_start(input string tag, input int slot);
        bus.rd_start_req  = 1'b1;
        bus.rd_start_slot = SLOT_W'(slot);
        @(negedge CLK);
        bus.rd_start_req  = 1'b0;
        check_eq({tag, "_ack"}, 32'(bus.rd_start_ack), 1);
        check_eq({tag, "_err"}, 32'(bus.rd_start_err), 0);
    endtask

    // stall=0: rd_ready held high, checks latency and back-to-back words; stall=1: rd_ready alternates
    task automatic read_collect(input string tag, input int n, input int base, input bit stall);
        int got_n = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        bit held_v = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp_w;
        for (int c = 0; c < 64 && got_n < n; c++) begin
            if (!stall || c > 0) @(negedge CLK);
            bus.rd_ready = stall ? (c % 2 == 1) : 1'b1;
            if (bus.rd_valid) begin
                if (held_v) check_eq($sformatf("%s_stable%0d", tag, got_n), 32'(bus.rd_data), 32'(held));
                held_v = 1'b0;
                if (bus.rd_ready) begin
                    exp_w = DW'(base + got_n);
                    if (first_cyc < 0) first_cyc = c;
                    last_cyc = c;
                    check_eq($sformatf("%s_w%0d", tag, got_n), 32'(bus.rd_data), 32'(exp_w));
                    check_eq($sformatf("%s_last%0d", tag, got_n), 32'(bus.rd_last), 32'(got_n == n - 1));
                    got_n++;
                end else begin
                    held_v = 1'b1;
                    held   = bus.rd_data;
                end
            end
        end
        check_eq({tag, "_count"}, 32'(got_n), 32'(n));
        if (!stall) begin
            check_eq({tag, "_first_lat"}, 32'(first_cyc >= 0 && first_cyc <= 1), 1);
            check_eq({tag, "_span"}, 32'(last_cyc - first_cyc), 32'(n - 1));
        end
        @(negedge CLK);
        check_eq({tag, "_valid_after"}, 32'(bus.rd_valid), 0);
        bus.rd_ready = 1'b1;
    endtask

    initial begin
        bit acked;
        bus.wr_alloc_req  = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = '0;
        bus.wr_last       = 1'b0;
        bus.rd_start_req  = 1'b0;
        bus.rd_start_slot = '0;
        bus.rd_ready      = 1'b1;
        bus.inv_req       = 1'b0;
        bus.inv_slot      = '0;

        repeat (3) @(negedge CLK);
        check_reset("rst0");
        RST_N = 1'b1;
        @(negedge CLK);

        // Basic packet and two identical reads
        do_alloc("a0", 0);
        write_pkt("w0", 5, 'h11, 5, 1'b0);
        read_start("r0", 0);
        read_collect("r0", 5, 'h11, 1'b0);
        read_start("r0b", 0);
        read_collect("r0b", 5, 'h11, 1'b0);

        // Oversized packet is dropped and its slot released
        do_alloc("a1", 1);
        write_pkt("wovf", DEPTH + 3, 'h80, DEPTH, 1'b1);
        check_eq("ovf_free_any", 32'(bus.free_any), 1);

        // Fill every slot
        do_alloc("a2", 1);
        write_pkt("w1", 3, 'h21, 3, 1'b0);
        do_alloc("a3", 2);
        write_pkt("w2", 2, 'h31, 2, 1'b0);
        do_alloc("a4", 3);
        write_pkt("w3", 1, 'h41, 1, 1'b0);
        check_eq("full_free_any", 32'(bus.free_any), 0);
`ifdef PRT_FREE_COUNT_EN
        check_eq("full_free_count", 32'(bus.free_count), 0);
`endif

        // Held alloc with no free slot, then freed by invalidate
        bus.wr_alloc_req = 1'b1;
        acked = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.wr_alloc_ack) acked = 1'b1;
        end
        check_eq("full_noack", 32'(acked), 0);
        bus.inv_req  = 1'b1;
        bus.inv_slot = SLOT_W'(3);
        @(negedge CLK);
        bus.inv_req  = 1'b0;
        check_eq("inv3_ack", 32'(bus.inv_ack), 1);
        check_eq("inv3_err", 32'(bus.inv_err), 0);
        do_alloc("a5", 3);
        write_pkt("w3b", 4, 'h51, 4, 1'b0);

        // Errors during an active read, then stalled drain
        bus.rd_ready = 1'b0;
        read_start("r1", 1);
        bus.inv_req  = 1'b1;
        bus.inv_slot = SLOT_W'(1);
        @(negedge CLK);
        bus.inv_req  = 1'b0;
        check_eq("inv_reading_err", 32'(bus.inv_err), 1);
        check_eq("inv_reading_ack", 32'(bus.inv_ack), 0);
        bus.rd_start_req  = 1'b1;
        bus.rd_start_slot = SLOT_W'(2);
        @(negedge CLK);
        bus.rd_start_req  = 1'b0;
        check_eq("rd_busy_err", 32'(bus.rd_start_err), 1);
        check_eq("rd_busy_ack", 32'(bus.rd_start_ack), 0);
        read_collect("r1", 3, 'h21, 1'b1);
        read_start("r3", 3);
        read_collect("r3", 4, 'h51, 1'b0);

        // Free slot 2, then rd_start and inv on slot 0 in the same cycle
        bus.inv_req  = 1'b1;
        bus.inv_slot = SLOT_W'(2);
        @(negedge CLK);
        check_eq("inv2_ack", 32'(bus.inv_ack), 1);
        bus.rd_ready      = 1'b0;
        bus.rd_start_req  = 1'b1;
        bus.rd_start_slot = SLOT_W'(0);
        bus.inv_slot      = SLOT_W'(0);
        @(negedge CLK);
        bus.rd_start_req = 1'b0;
        bus.inv_req      = 1'b0;
        check_eq("race_rd_ack", 32'(bus.rd_start_ack), 1);
        check_eq("race_inv_err", 32'(bus.inv_err), 1);
        check_eq("race_inv_ack", 32'(bus.inv_ack), 0);

        // Reset in the middle of a write and a read
        do_alloc("a6", 2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h61;
        @(negedge CLK);
        bus.wr_data  = 8'h62;
        @(negedge CLK);
        bus.wr_valid = 1'b0;
        check_eq("mid_wr_ready", 32'(bus.wr_ready), 1);
        check_eq("mid_rd_valid", 32'(bus.rd_valid), 1);
        check_eq("mid_rd_data", 32'(bus.rd_data), 'h11);
        RST_N = 1'b0;
        #1;
        check_reset("rst1");
        @(negedge CLK);
        RST_N = 1'b1;
        bus.rd_ready = 1'b1;
        @(negedge CLK);
        do_alloc("a_post", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
